regfile_writeback_arbiter: RTL and testbench
============================================

Name: regfile_writeback_arbiter

Overview:
Owns the single write port of the 32x32 general register file. It merges two result sources onto that port.
- Source 1 is the in-order pipeline WB stage. It has fixed priority and no backpressure.
- Source 2 is the long-latency unit (mul/div/cache-miss load return). It uses a valid/ready handshake and is buffered in a small FIFO that drains into idle WB slots.
- A pending-register mask is exported to ID for RAW/WAW hazard detection.

Parameters:
WIDTH, 32, data width of a register
ADDR_WIDTH, 5, register index width
DEPTH, 4, long-latency FIFO entries; power of two, >= 2

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
wb_we  input  1  pipeline WB write enable
wb_addr  input  ADDR_WIDTH  pipeline WB destination register
wb_data  input  WIDTH  pipeline WB data
lu_valid  input  1  long-latency result valid
lu_ready  output  1  arbiter can accept the long-latency result this cycle
lu_addr  input  ADDR_WIDTH  long-latency destination register
lu_data  input  WIDTH  long-latency result data
reg_write  output  1  register file write enable
write_register  output  ADDR_WIDTH  register file write index
write_data  output  WIDTH  register file write data
pend_mask  output  2**ADDR_WIDTH  bit r set: a valid FIFO entry targets register r
fifo_count  output  log2(DEPTH)+1  occupied FIFO entries, valid and killed

Behaviour:
- Reset (async, rst_n=0): FIFO empty, all entry valid bits 0, pointers 0, fifo_count=0, pend_mask=0. Outputs forced low: reg_write=0, write_register=0, write_data=0, lu_ready=0. Reset mid-drain discards all queued results.
- Handshake: lu_ready = rst_n && (fifo_count < DEPTH). A transfer occurs when lu_valid && lu_ready. lu_addr/lu_data must stay stable while lu_valid=1 and lu_ready=0.
- WB slot is "busy" when wb_we && wb_addr != 0; otherwise it is "free".
- Write port selection is combinational, same cycle, zero latency, in this priority:
  1. Slot busy: reg_write=1, write_register=wb_addr, write_data=wb_data.
  2. Slot free and FIFO head valid: write the head entry and pop it.
  3. Slot free, FIFO empty, transfer occurring, lu_addr != 0, and no kill (see ordering rule): bypass straight through. Write lu_addr/lu_data; nothing is enqueued.
  4. Otherwise reg_write=0; write_register and write_data hold 0.
- Enqueue: a transfer not consumed by the bypass is enqueued at the tail with valid=1. Exceptions: lu_addr==0 is accepted and discarded; a killed transfer (see ordering rule) is accepted and discarded.
- Ordering rule: every long-latency result is program-older than any concurrent pipeline WB write. When the slot is busy with address X:
  - every valid FIFO entry with addr X has its valid bit cleared that cycle;
  - a same-cycle transfer with lu_addr X is discarded.
- Killed (invalid) head: popped in any cycle without producing a write. This is independent of slot state and costs one cycle.
- Simultaneous push and pop: allowed, including when full. lu_ready is based on the registered count, so a full FIFO refuses the transfer even if it pops that cycle.
- Pointers: wrap modulo DEPTH. fifo_count updates +1/-1/0 per cycle.
- pend_mask: OR over valid entries of the one-hot of their addr, driven from registered state. A same-cycle bypass does not set any bit.
- Invariant: at most one register file write per cycle; there is no path by which an older result overwrites a younger one.

Test Plan:
- Pipeline priority: wb_we=1, wb_addr=5, wb_data=0x11, lu_valid=1 to r7=0x22, FIFO empty -> same cycle write r5=0x11, lu entry enqueued (count=1, pend_mask bit7=1); next cycle with wb_we=0 -> write r7=0x22, count=0, pend_mask=0.
- Bypass: FIFO empty, wb_we=0, lu_valid=1 r9=0xABCD -> reg_write=1 same cycle, write r9=0xABCD, count stays 0, pend_mask stays 0.
- Full/backpressure: hold wb_we=1 (r1) for 6 cycles while lu_valid=1 with distinct addrs r10..r15 -> 4 accepted, lu_ready=0 once count=4. Release WB -> drains r10..r13 in order, one per cycle; then r14 and r15 accepted in turn; r14 and r15 are never dropped.
- WAW kill: FIFO holds r3=0x1 (valid); WB writes r3=0x2 -> entry invalidated, pend_mask bit3 clears next cycle. The head pops with no write; final r3 value written is 0x2 only.
- Zero register: lu transfer to r0 with 0xFFFF -> lu_ready handshake completes, no write, count unchanged. wb_we=1 with wb_addr=0 -> slot treated free, FIFO head drains that cycle.
- Async reset mid-operation: count=3, assert rst_n=0 between clock edges -> reg_write, lu_ready, fifo_count and pend_mask go 0 immediately. After release, no stale entry is ever written.

Source files
------------

// File: rtl/regfile_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writeback_arbiter
// Purpose  : Merges pipeline WB and buffered long-latency results onto the
//            single register-file write port; exports a pending-register mask.
// Revision : 1.0
// ============================================================================
module regfile_writeback_arbiter #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wb_we,
    input  logic [ADDR_WIDTH-1:0]         wb_addr,
    input  logic [WIDTH-1:0]              wb_data,
    input  logic                          lu_valid,
    output logic                          lu_ready,
    input  logic [ADDR_WIDTH-1:0]         lu_addr,
    input  logic [WIDTH-1:0]              lu_data,
    output logic                          reg_write,
    output logic [ADDR_WIDTH-1:0]         write_register,
    output logic [WIDTH-1:0]              write_data,
    output logic [2**ADDR_WIDTH-1:0]      pend_mask,
    output logic [$clog2(DEPTH):0]        fifo_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    logic [DEPTH-1:0]      r_valid;
    logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
    logic [WIDTH-1:0]      r_data [DEPTH];
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_CNT_W-1:0]    r_count;

    logic w_busy;
    logic w_empty;
    logic w_head_valid;
    logic w_xfer;
    logic w_kill_lu;
    logic w_bypass;
    logic w_push;
    logic w_pop;

    assign lu_ready     = rst_n && (r_count < c_FULL);
    assign fifo_count   = r_count;

    assign w_busy       = wb_we && (wb_addr != '0);
    assign w_empty      = (r_count == '0);
    assign w_head_valid = !w_empty && r_valid[r_rd_ptr];
    assign w_xfer       = lu_valid && lu_ready;
    // Long-latency results are always program-older than a concurrent WB write.
    assign w_kill_lu    = w_busy && (lu_addr == wb_addr);
    assign w_bypass     = !w_busy && w_empty && w_xfer && (lu_addr != '0) && !w_kill_lu;
    assign w_push       = w_xfer && (lu_addr != '0) && !w_kill_lu && !w_bypass;
    // A killed head leaves regardless of slot state; a live head needs a free slot.
    assign w_pop        = !w_empty && (!r_valid[r_rd_ptr] || !w_busy);

    always_comb begin
        reg_write      = 1'b0;
        write_register = '0;
        write_data     = '0;
        if (rst_n) begin
            if (w_busy) begin
                reg_write      = 1'b1;
                write_register = wb_addr;
                write_data     = wb_data;
            end else if (w_head_valid) begin
                reg_write      = 1'b1;
                write_register = r_addr[r_rd_ptr];
                write_data     = r_data[r_rd_ptr];
            end else if (w_bypass) begin
                reg_write      = 1'b1;
                write_register = lu_addr;
                write_data     = lu_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_busy && r_valid[i] && (r_addr[i] == wb_addr)) begin
                    r_valid[i] <= 1'b0;
                end
            end
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage is qualified by r_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= lu_addr;
            r_data[r_wr_ptr] <= lu_data;
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i]) begin
                pend_mask[r_addr[i]] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_writeback_arbiter
// Purpose  : Directed, table-driven self-checking bench for the WB arbiter.
// Revision : 1.0
// ============================================================================
module tb_regfile_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic        reg_write;
    logic [4:0]  write_register;
    logic [31:0] write_data;
    logic [31:0] pend_mask;
    logic [2:0]  fifo_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_writeback_arbiter #(
        .WIDTH      (32),
        .ADDR_WIDTH (5),
        .DEPTH      (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wb_we          (wb_we),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .lu_valid       (lu_valid),
        .lu_ready       (lu_ready),
        .lu_addr        (lu_addr),
        .lu_data        (lu_data),
        .reg_write      (reg_write),
        .write_register (write_register),
        .write_data     (write_data),
        .pend_mask      (pend_mask),
        .fifo_count     (fifo_count)
    );

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        lv;
        logic [4:0]  laddr;
        logic [31:0] ldata;
        logic        e_rw;
        logic [4:0]  e_reg;
        logic [31:0] e_data;
        logic        e_rdy;
        logic [2:0]  e_cnt;
        logic [31:0] e_pend;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s idx=%0d actual=0x%0h expected=0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                         input logic lv, input logic [4:0] laddr, input logic [31:0] ldata);
        wb_we    = we;
        wb_addr  = waddr;
        wb_data  = wdata;
        lu_valid = lv;
        lu_addr  = laddr;
        lu_data  = ldata;
    endtask

    task automatic add(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                       input logic lv, input logic [4:0] laddr, input logic [31:0] ldata,
                       input logic e_rw, input logic [4:0] e_reg, input logic [31:0] e_data,
                       input logic e_rdy, input logic [2:0] e_cnt, input logic [31:0] e_pend);
        vec_t v;
        v = '{we, waddr, wdata, lv, laddr, ldata, e_rw, e_reg, e_data, e_rdy, e_cnt, e_pend};
        vecs.push_back(v);
    endtask

    initial begin
        // Each row is one cycle: inputs, then the expected combinational write
        // port plus count/mask as registered at the start of that cycle.
        //   we wa  wdata   lv la  ldata      rw reg data     rdy cnt pend
        add(0, 0,  32'h0,  0, 0,  32'h0,     0, 0,  32'h0,    1, 0, 32'h0);
        // pipeline priority, then deferred drain
        add(1, 5,  32'h11, 1, 7,  32'h22,    1, 5,  32'h11,   1, 0, 32'h0);
        add(0, 0,  32'h0,  0, 0,  32'h0,     1, 7,  32'h22,   1, 1, 32'h80);
        add(0, 0,  32'h0,  0, 0,  32'h0,     0, 0,  32'h0,    1, 0, 32'h0);
        // bypass
        add(0, 0,  32'h0,  1, 9,  32'hABCD,  1, 9,  32'hABCD, 1, 0, 32'h0);
        add(0, 0,  32'h0,  0, 0,  32'h0,     0, 0,  32'h0,    1, 0, 32'h0);
        // long-latency result to r0 is accepted and dropped
        add(0, 0,  32'h0,  1, 0,  32'hFFFF,  0, 0,  32'h0,    1, 0, 32'h0);
        add(0, 0,  32'h0,  0, 0,  32'h0,     0, 0,  32'h0,    1, 0, 32'h0);
        // WAW kill of a queued r3
        add(1, 1,  32'h5,  1, 3,  32'h1,     1, 1,  32'h5,    1, 0, 32'h0);
        add(1, 3,  32'h2,  0, 0,  32'h0,     1, 3,  32'h2,    1, 1, 32'h8);
        add(0, 0,  32'h0,  0, 0,  32'h0,     0, 0,  32'h0,    1, 1, 32'h0);
        add(0, 0,  32'h0,  0, 0,  32'h0,     0, 0,  32'h0,    1, 0, 32'h0);
        // WB to r0 leaves the slot free for the FIFO head
        add(1, 2,  32'h7,  1, 4,  32'h44,    1, 2,  32'h7,    1, 0, 32'h0);
        add(1, 0,  32'h99, 0, 0,  32'h0,     1, 4,  32'h44,   1, 1, 32'h10);
        add(0, 0,  32'h0,  0, 0,  32'h0,     0, 0,  32'h0,    1, 0, 32'h0);
        // fill to full under a busy slot, backpressure, then ordered drain
        add(1, 1,  32'hA1, 1, 10, 32'h10A,   1, 1,  32'hA1,   1, 0, 32'h0);
        add(1, 1,  32'hA1, 1, 11, 32'h10B,   1, 1,  32'hA1,   1, 1, 32'h400);
        add(1, 1,  32'hA1, 1, 12, 32'h10C,   1, 1,  32'hA1,   1, 2, 32'hC00);
        add(1, 1,  32'hA1, 1, 13, 32'h10D,   1, 1,  32'hA1,   1, 3, 32'h1C00);
        add(1, 1,  32'hA1, 1, 14, 32'h10E,   1, 1,  32'hA1,   0, 4, 32'h3C00);
        add(1, 1,  32'hA1, 1, 14, 32'h10E,   1, 1,  32'hA1,   0, 4, 32'h3C00);
        add(0, 0,  32'h0,  1, 14, 32'h10E,   1, 10, 32'h10A,  0, 4, 32'h3C00);
        add(0, 0,  32'h0,  1, 14, 32'h10E,   1, 11, 32'h10B,  1, 3, 32'h3800);
        add(0, 0,  32'h0,  1, 15, 32'h10F,   1, 12, 32'h10C,  1, 3, 32'h7000);
        add(0, 0,  32'h0,  0, 0,  32'h0,     1, 13, 32'h10D,  1, 3, 32'hE000);
        add(0, 0,  32'h0,  0, 0,  32'h0,     1, 14, 32'h10E,  1, 2, 32'hC000);
        add(0, 0,  32'h0,  0, 0,  32'h0,     1, 15, 32'h10F,  1, 1, 32'h8000);
        add(0, 0,  32'h0,  0, 0,  32'h0,     0, 0,  32'h0,    1, 0, 32'h0);

        // reset state, with a busy WB request that must be masked
        rst_n = 1'b0;
        drive(1, 5, 32'h55, 1, 6, 32'h66);
        #2;
        chk("rst_reg_write", -1, 32'(reg_write), 32'h0);
        chk("rst_write_register", -1, 32'(write_register), 32'h0);
        chk("rst_write_data", -1, write_data, 32'h0);
        chk("rst_lu_ready", -1, 32'(lu_ready), 32'h0);
        chk("rst_fifo_count", -1, 32'(fifo_count), 32'h0);
        chk("rst_pend_mask", -1, pend_mask, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata,
                  vecs[i].lv, vecs[i].laddr, vecs[i].ldata);
            #2;
            chk("reg_write", i, 32'(reg_write), 32'(vecs[i].e_rw));
            chk("write_register", i, 32'(write_register), 32'(vecs[i].e_reg));
            chk("write_data", i, write_data, vecs[i].e_data);
            chk("lu_ready", i, 32'(lu_ready), 32'(vecs[i].e_rdy));
            chk("fifo_count", i, 32'(fifo_count), 32'(vecs[i].e_cnt));
            chk("pend_mask", i, pend_mask, vecs[i].e_pend);
        end

        // async reset mid-drain with three queued entries
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1, 1, 32'hA1, 1, 5'(20 + k), 32'h200 + 32'(k));
        end
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        #1;
        chk("pre_rst_count", 100, 32'(fifo_count), 32'h3);
        chk("pre_rst_write_register", 100, 32'(write_register), 32'd20);
        chk("pre_rst_pend_mask", 100, pend_mask, 32'h0070_0000);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_reg_write", 101, 32'(reg_write), 32'h0);
        chk("async_rst_lu_ready", 101, 32'(lu_ready), 32'h0);
        chk("async_rst_fifo_count", 101, 32'(fifo_count), 32'h0);
        chk("async_rst_pend_mask", 101, pend_mask, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(0, 0, 32'h0, 0, 0, 32'h0);
            #2;
            chk("post_rst_reg_write", 110 + k, 32'(reg_write), 32'h0);
            chk("post_rst_fifo_count", 110 + k, 32'(fifo_count), 32'h0);
        end
        @(negedge clk);
        drive(0, 0, 32'h0, 1, 6, 32'h66);
        #2;
        chk("post_rst_bypass_we", 120, 32'(reg_write), 32'h1);
        chk("post_rst_bypass_reg", 120, 32'(write_register), 32'd6);
        chk("post_rst_bypass_data", 120, write_data, 32'h66);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        #2;
        chk("post_bypass_count", 121, 32'(fifo_count), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
